// File: rtl/vetris_link_pkg.sv
// Shared types for the write-back row link: FSM states, frame layout, FIFO entry.
// Optional parity beat is enabled by defining WB_ROW_TX_PARITY_EN.
package vetris_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    PAR
  } state_e;

  localparam logic [2:0] HDR_TAG_DEF = 3'b101;
  localparam int DATA_BEATS = 4;
  localparam int ROW_IDX_W  = 5;
  localparam int BEAT_W     = 2;

  typedef struct packed {
    logic [ROW_IDX_W-1:0] index;
    logic [31:0]          data;
  } row_req_t;

  // Beat 0 carries the most significant byte.
  function automatic logic [7:0] row_byte(
    input logic [31:0]       d,
    input logic [BEAT_W-1:0] b
  );
    return d[8*(DATA_BEATS-1-int'(b)) +: 8];
  endfunction

endpackage

// File: rtl/wb_row_tx_row_fifo.sv
// Small synchronous FIFO of row requests, no bypass.
// Push is refused when full; pop is ignored when empty.
module row_fifo
  import vetris_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  row_req_t                 din_i,
  input  logic                     pop_i,
  output row_req_t                 dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  row_req_t       mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_row_tx.sv
// Queues WB row-send requests and serializes each as header + data bytes.
// Define WB_ROW_TX_PARITY_EN to append an XOR parity beat to every frame.
module wb_row_tx
  import vetris_link_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter logic [2:0] HDR_TAG = HDR_TAG_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send_row_in,
  input  logic [ROW_IDX_W-1:0] row_index_in,
  input  logic [31:0]          row_data_in,
  output logic                 stall_out,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_sof,
  output logic                 busy,
  output logic                 overflow
);

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  row_req_t               frame_q, frame_d;
  logic [7:0]             par_q, par_d;
  logic                   ovf_q;
  logic                   pop;
  logic                   fin;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  row_req_t               head;
  row_req_t               req;

  assign req = '{index: row_index_in, data: row_data_in};

  row_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (send_row_in),
    .din_i   (req),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign stall_out = full;
  assign overflow  = ovf_q;
  assign busy      = (count != '0) || (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      frame_q <= '0;
      par_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      frame_q <= frame_d;
      par_q   <= par_d;
      ovf_q   <= ovf_q | (send_row_in & full);
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    frame_d  = frame_q;
    par_d    = par_q;
    pop      = 1'b0;
    fin      = 1'b0;
    tx_valid = 1'b0;
    tx_sof   = 1'b0;
    tx_data  = 8'h00;
    unique case (state_q)
      IDLE: fin = 1'b1;
      HDR: begin
        tx_valid = 1'b1;
        tx_sof   = 1'b1;
        tx_data  = {HDR_TAG, frame_q.index};
        if (tx_ready) begin
          par_d   = par_q ^ tx_data;
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = row_byte(frame_q.data, beat_q);
        if (tx_ready) begin
          par_d = par_q ^ tx_data;
          if (beat_q == BEAT_W'(DATA_BEATS-1)) begin
`ifdef WB_ROW_TX_PARITY_EN
            state_d = PAR;
`else
            fin = 1'b1;
`endif
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      PAR: begin
`ifdef WB_ROW_TX_PARITY_EN
        tx_valid = 1'b1;
        tx_data  = par_q;
        if (tx_ready) fin = 1'b1;
`else
        state_d = IDLE;
`endif
      end
    endcase
    // Frame end chains straight into the next queued request.
    if (fin) begin
      if (!empty) begin
        pop     = 1'b1;
        frame_d = head;
        par_d   = 8'h00;
        state_d = HDR;
      end else begin
        state_d = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_wb_row_tx.sv
// Scoreboard bench for wb_row_tx: model frames queued at push, monitor pops on accept.
// Define WB_ROW_TX_PARITY_EN to expect the parity beat.
module tb_wb_row_tx;

  localparam int DEPTH = 4;
`ifdef WB_ROW_TX_PARITY_EN
  localparam int FB = 6;
`else
  localparam int FB = 5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_row_in = 1'b0;
  logic [4:0]  row_index_in = '0;
  logic [31:0] row_data_in = '0;
  logic        tx_ready = 1'b0;
  logic        stall_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_sof;
  logic        busy;
  logic        overflow;

  wb_row_tx #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .send_row_in  (send_row_in),
    .row_index_in (row_index_in),
    .row_data_in  (row_data_in),
    .stall_out    (stall_out),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_sof       (tx_sof),
    .busy         (busy),
    .overflow     (overflow)
  );

  typedef struct {
    logic [7:0] b;
    bit         sof;
    bit         last;
  } beat_t;

  beat_t exp_q[$];
  int    acc_cyc[$];
  int    passed = 0;
  int    total = 0;
  int    cyc = 0;
  int    rmode = 3;
  int    pushed = 0;
  int    done_fr = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Frame built directly from the link format: tag|index, data MSB first, XOR.
  task automatic model_frame(input logic [4:0] idx, input logic [31:0] d);
    logic [7:0] by[6];
    by[0] = {3'b101, idx};
    for (int i = 0; i < 4; i++) by[i+1] = 8'((d >> (24 - 8*i)) & 32'hFF);
    by[5] = by[0] ^ by[1] ^ by[2] ^ by[3] ^ by[4];
    for (int i = 0; i < FB; i++) exp_q.push_back('{by[i], i == 0, i == FB-1});
    pushed++;
  endtask

  task automatic push(input logic [4:0] idx, input logic [31:0] d, input bit acc);
    send_row_in  = 1'b1;
    row_index_in = idx;
    row_data_in  = d;
    if (acc) model_frame(idx, d);
    @(posedge clk);
    #1;
    send_row_in = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d beats left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Sink-side ready generator.
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  end

  // Monitor: handshake stability and scoreboard pop on every accepted beat.
  initial begin
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       p_rst = 1'b1;
    logic [7:0] p_data = '0;
    logic       p_sof = 1'b0;
    beat_t      it;
    forever begin
      @(negedge clk);
      if (!rst && !p_rst && p_valid && !p_ready) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, p_data);
        chk("hold_sof", tx_sof, p_sof);
      end
      if (!rst && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat: got %0h expected none", tx_data);
        end else begin
          it = exp_q.pop_front();
          chk("beat_data", tx_data, it.b);
          chk("beat_sof", tx_sof, it.sof);
          acc_cyc.push_back(cyc);
          if (it.last) done_fr++;
        end
      end
      p_valid = tx_valid;
      p_ready = tx_ready;
      p_rst   = rst;
      p_data  = tx_data;
      p_sof   = tx_sof;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    step(3);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_sof", tx_sof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // Single frame, ready high, latency check
    rmode = 0;
    step(2);
    push(5'd3, 32'hDEADBEEF, 1);
    chk("lat_n1_valid", tx_valid, 0);
    step(1);
    chk("lat_n2_valid", tx_valid, 1);
    chk("lat_n2_sof", tx_sof, 1);
    chk("lat_n2_hdr", tx_data, 8'hA3);
    drain();
    chk("single_busy_end", busy, 0);

    // Same frame, ready toggling
    rmode = 1;
    acc_cyc.delete();
    push(5'd3, 32'hDEADBEEF, 1);
    drain();
    chk("toggle_beats", acc_cyc.size(), FB);
    chk("toggle_busy_end", busy, 0);

    // Fill FIFO behind a stalled frame; fifth queued push is dropped
    rmode = 3;
    step(2);
    push(5'd1, 32'h11111111, 1);
    step(3);
    chk("ovf_stall0", stall_out, 0);
    push(5'd2, 32'h22222222, 1);
    push(5'd4, 32'h44444444, 1);
    push(5'd8, 32'h88888888, 1);
    chk("ovf_stall3", stall_out, 0);
    push(5'd16, 32'h16161616, 1);
    chk("ovf_stall4", stall_out, 1);
    chk("ovf_pre", overflow, 0);
    push(5'd31, 32'h31313131, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_stall_held", stall_out, 1);
    rmode = 0;
    drain();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_stall_end", stall_out, 0);
    chk("ovf_busy_end", busy, 0);

    // Back-to-back frames with no gap
    acc_cyc.delete();
    push(5'd0, 32'h00000001, 1);
    push(5'd31, 32'hFFFFFFFF, 1);
    drain();
    chk("b2b_beats", acc_cyc.size(), 2*FB);
    if (acc_cyc.size() == 2*FB)
      chk("b2b_span", acc_cyc[2*FB-1] - acc_cyc[0], 2*FB-1);

    // Reset during data beat 2
    push(5'd7, 32'h12345678, 1);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_q.delete();
    done_fr = pushed;
    chk("mrst_valid", tx_valid, 0);
    chk("mrst_data", tx_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_stall", stall_out, 0);
    step(3);
    chk("mrst_idle", tx_valid, 0);
    push(5'd9, 32'hCAFEF00D, 1);
    drain();

    // Randomized traffic with random sink back-pressure
    rmode = 2;
    for (int k = 0; k < 40; k++) begin
      w = 0;
      while (pushed - done_fr >= DEPTH && w < 300) begin
        step(1);
        w++;
      end
      if (pushed - done_fr >= DEPTH) begin
        total++;
        $display("FAIL flow_timeout: outstanding %0d expected < %0d", pushed - done_fr, DEPTH);
      end
      step($urandom_range(0, 2));
      push(5'($urandom_range(0, 31)), $urandom, 1);
    end
    drain();
    chk("rand_busy_end", busy, 0);
    chk("rand_ovf", overflow, 0);
    chk("rand_frames", done_fr, pushed);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
